// File: rtl/sum5x4_collector.sv
// Five-operand 4-bit collector: accepts operands over valid/ready, banks them,
// keeps a running sum and hands the full group downstream once five are in.
module sum5x4_collector #(
    parameter int N_OPS = 5,
    parameter int W     = 4,
    parameter int SUM_W = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [W-1:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N_OPS*W-1:0] ops,
    output logic [SUM_W-1:0]   sum,
    output logic [2:0]         count,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;

    state_t                      state, state_nxt;
    logic [N_OPS-1:0][W-1:0]     bank;
    logic [SUM_W-1:0]            acc;
    logic [2:0]                  cnt;
    logic                        accept;
    logic                        drain;
    logic                        last;

    // flush outranks an accept in the same cycle; reset outranks everything
    assign accept = in_valid && (state == COLLECT) && !flush;
    assign drain  = flush || ((state == DONE) && out_ready);
    assign last   = (cnt == 3'(N_OPS - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= COLLECT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = COLLECT;
        end else begin
            case (state)
                COLLECT: if (accept && last) state_nxt = DONE;
                DONE:    if (out_ready)      state_nxt = COLLECT;
                default:                     state_nxt = COLLECT;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == COLLECT);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            acc <= '0;
        end else if (drain) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            cnt <= cnt + 3'd1;
            acc <= acc + SUM_W'(in_data);
        end
    end

    // Bank entries survive a drain; each is rewritten only by its own next accept.
    for (genvar k = 0; k < N_OPS; k++) begin : g_bank
        always_ff @(posedge clk) begin
            if (reset)
                bank[k] <= '0;
            else if (accept && (cnt == 3'(k)))
                bank[k] <= in_data;
        end
    end

    assign ops   = bank;
    assign sum   = acc;
    assign count = cnt;

endmodule

// File: tb/tb_sum5x4_collector.sv
// Directed self-checking bench for sum5x4_collector.
module tb_sum5x4_collector;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [3:0]  in_data;
    logic        in_ready, out_valid;
    logic [19:0] ops;
    logic [6:0]  sum;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    sum5x4_collector dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ops       (ops),
        .sum       (sum),
        .count     (count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [3:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
    endtask

    task automatic chk_all(input string tag, input logic ir, input logic ov,
                           input logic [6:0] s, input logic [2:0] c, input logic [19:0] o);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".sum"},       32'(sum),       32'(s));
        chk({tag, ".count"},     32'(count),     32'(c));
        chk({tag, ".ops"},       32'(ops),       32'(o));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk_all("reset", 1'b1, 1'b0, 7'd0, 3'd0, 20'h0);

        // 1..5 back to back
        feed(4'd1); feed(4'd2); feed(4'd3);
        chk("t1.mid_count", 32'(count), 32'd3);
        chk("t1.mid_sum",   32'(sum),   32'd6);
        feed(4'd4); feed(4'd5);
        in_valid = 1'b0;
        chk_all("t1.done", 1'b0, 1'b1, 7'd15, 3'd5, 20'h54321);
        tick();
        chk_all("t1.hold", 1'b0, 1'b1, 7'd15, 3'd5, 20'h54321);
        out_ready = 1'b1;
        tick();
        chk_all("t1.drain", 1'b1, 1'b0, 7'd0, 3'd0, 20'h54321);

        // max operands with out_ready held high
        repeat (5) feed(4'd15);
        in_valid = 1'b0;
        chk_all("t2.done", 1'b0, 1'b1, 7'b1001011, 3'd5, 20'hFFFFF);
        tick();
        chk("t2.ov_one_cycle", 32'(out_valid), 32'd0);
        chk("t2.in_ready",     32'(in_ready),  32'd1);
        out_ready = 1'b0;

        // stall in DONE with a 6 offered on the input
        feed(4'd3); feed(4'd0); feed(4'd7); feed(4'd9); feed(4'd1);
        in_data = 4'd6;
        for (int i = 0; i < 4; i++) begin
            chk_all($sformatf("t3.stall%0d", i), 1'b0, 1'b1, 7'd20, 3'd5, 20'h19703);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_all("t3.drain", 1'b1, 1'b0, 7'd0, 3'd0, 20'h19703);
        feed(4'd6);
        in_valid = 1'b0;
        chk_all("t3.restart", 1'b1, 1'b0, 7'd6, 3'd1, 20'h19706);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // gaps then flush with an operand offered
        feed(4'd2);
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("t4.gap_count", 32'(count), 32'd1);
        chk("t4.gap_sum",   32'(sum),   32'd2);
        feed(4'd4);
        chk("t4.sum2", 32'(sum), 32'd6);
        flush = 1'b1; in_data = 4'd9;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk_all("t4.flush", 1'b1, 1'b0, 7'd0, 3'd0, 20'h19742);
        repeat (5) feed(4'd1);
        in_valid = 1'b0;
        chk_all("t4.ones", 1'b0, 1'b1, 7'd5, 3'd5, 20'h11111);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // reset mid-group with an operand offered
        feed(4'd7); feed(4'd8); feed(4'd9);
        chk("t5.pre_ops", 32'(ops), 32'h11987);
        reset = 1'b1; in_data = 4'd5; in_valid = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk_all("t5.reset", 1'b1, 1'b0, 7'd0, 3'd0, 20'h0);

        // reset and flush together in DONE
        repeat (5) feed(4'd15);
        in_valid = 1'b0;
        chk("t6.pre_ov", 32'(out_valid), 32'd1);
        reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        chk_all("t6.reset_flush", 1'b1, 1'b0, 7'd0, 3'd0, 20'h0);

        // flush alone drops a group in DONE
        repeat (5) feed(4'd2);
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_all("t7.flush_done", 1'b1, 1'b0, 7'd0, 3'd0, 20'h22222);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
